// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Word-addressed data RAM that sits behind a posted-write queue.
//            Writes are queued and retired to RAM in cycles where the core
//            is not reading. Reads see the youngest queued value for their
//            word, if there is one. A flush request drains the whole queue
//            while the core is held off.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int QDEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  input  logic        flush,
  output logic        idle
);

  // Pointer width indexes the queue slots. Count width holds 0..QDEPTH.
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(QDEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  localparam logic [1:0] ST_EMPTY    = 2'd0;
  localparam logic [1:0] ST_BUFFER   = 2'd1;
  localparam logic [1:0] ST_FULL     = 2'd2;
  localparam logic [1:0] ST_FLUSHING = 2'd3;

  // Control state
  logic [1:0]    state_q, state_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // Queue storage: each entry holds a word index and its data
  logic [ADDR_WIDTH-1:0] q_idx_q  [QDEPTH];
  logic [31:0]           q_data_q [QDEPTH];

  // Backing RAM. It is never reset.
  logic [31:0] ram_q [2**ADDR_WIDTH];

  // Request decode and handshake
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_flushing;
  logic                  w_nonempty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_stall_raw;
  logic                  w_push;

  // Read path
  logic                  w_fwd_hit;
  logic [31:0]           w_fwd_data;
  logic [PW-1:0]         w_slot;

  // Byte-offset bits and bits above the RAM size do not select a word.
  // Dropping them makes out-of-range addresses alias modulo the RAM size.
  logic w_unused_addr;
  assign w_unused_addr = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};

  assign w_idx      = mem_addr[ADDR_WIDTH+1:2];
  assign w_flushing = (state_q == ST_FLUSHING);
  assign w_nonempty = (count_q != CNT_ZERO);
  assign w_full     = (count_q == CNT_FULL);

  // The head entry retires whenever the RAM port is free. A read owns the
  // port, except during a flush, when the core is stalled anyway.
  assign w_pop = w_nonempty && (w_flushing || !mem_ren);

  // A full queue accepts a write only if a slot frees up in the same cycle.
  assign w_stall_raw = w_flushing || (mem_wen && w_full && !w_pop);
  assign w_push      = mem_wen && !w_stall_raw;

  // Reset forces the handshake outputs to their quiescent values.
  assign mem_stall = rst && w_stall_raw;
  assign idle      = !rst || (state_q == ST_EMPTY);

  // Next pointer and occupancy values from this cycle's push and pop
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (w_pop) begin
      head_d = head_q + PTR_ONE;
    end
    if (w_push) begin
      tail_d = tail_q + PTR_ONE;
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Queue state follows the next occupancy. A flush request is honoured
  // only when entries will remain to drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FLUSHING: begin
        if (count_d == CNT_ZERO) begin
          state_d = ST_EMPTY;
        end
      end
      default: begin
        if (flush && (state_q != ST_EMPTY) && (count_d != CNT_ZERO)) begin
          state_d = ST_FLUSHING;
        end else if (count_d == CNT_ZERO) begin
          state_d = ST_EMPTY;
        end else if (count_d == CNT_FULL) begin
          state_d = ST_FULL;
        end else begin
          state_d = ST_BUFFER;
        end
      end
    endcase
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // An accepted write lands in the tail slot
  always_ff @(posedge clk) begin
    if (w_push) begin
      q_idx_q[tail_q]  <= w_idx;
      q_data_q[tail_q] <= mem_dout;
    end
  end

  // The retiring head entry is written to RAM. It is blocked during reset
  // so that discarded entries never reach memory.
  always_ff @(posedge clk) begin
    if (rst && w_pop) begin
      ram_q[q_idx_q[head_q]] <= q_data_q[head_q];
    end
  end

  // Scan the valid entries from oldest to youngest. A later hit overrides
  // an earlier one, so the youngest match wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_slot     = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      w_slot = head_q + PW'(i);
      if ((CW'(i) < count_q) && (q_idx_q[w_slot] == w_idx)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = q_data_q[w_slot];
      end
    end
  end

  // Read data: zero when idle, else the queued value or the RAM word
  always_comb begin
    mem_din = '0;
    if (mem_ren) begin
      mem_din = w_fwd_hit ? w_fwd_data : ram_q[w_idx];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Brief    : Directed and random stimulus for data_mem_responder, checked
//            against a queue/array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  localparam int AW = 10;
  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        mem_stall;
  logic        flush;
  logic        idle;

  int checks = 0;
  int errors = 0;

  // Reference model: posted writes in age order, RAM image, flush-in-progress
  typedef struct packed {
    logic [AW-1:0] idx;
    logic [31:0]   data;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] ram_m [1 << AW];
  bit          m_flush = 1'b0;

  // Observed outputs of the most recent cycle
  logic [31:0] obs_din;
  logic        obs_stall;
  logic        obs_idle;

  logic [31:0] d0, d1, d2, p0, p1;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(AW), .QDEPTH(QD)) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_ren  (mem_ren),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .mem_dout (mem_dout),
    .mem_din  (mem_din),
    .mem_stall(mem_stall),
    .flush    (flush),
    .idle     (idle)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [AW-1:0] idx);
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].idx == idx) return mq[i].data;
    end
    return ram_m[idx];
  endfunction

  // One clock cycle: drive, check outputs against the model, step the model
  task automatic cyc(input logic r_n, input logic ren, input logic wen,
                     input logic [31:0] addr, input logic [31:0] data, input logic fl);
    logic [AW-1:0] idx;
    bit            pop, stall, push, was_nonempty;
    logic [31:0]   e_din;
    @(negedge clk);
    rst      = r_n;
    mem_ren  = ren;
    mem_wen  = wen;
    mem_addr = addr;
    mem_dout = data;
    flush    = fl;
    #1;
    idx   = addr[AW+1:2];
    pop   = (mq.size() > 0) && (m_flush || !ren);
    stall = m_flush || (wen && (mq.size() == QD) && !pop);
    push  = wen && !stall;
    e_din = ren ? model_read(idx) : 32'h0;
    obs_din   = mem_din;
    obs_stall = mem_stall;
    obs_idle  = idle;
    if (!m_flush) chk("din", mem_din, e_din);
    chk("stall", {31'b0, mem_stall}, r_n ? {31'b0, stall} : 32'h0);
    chk("idle", {31'b0, idle}, r_n ? {31'b0, (mq.size() == 0) && !m_flush} : 32'h1);
    @(posedge clk);
    #1;
    if (!r_n) begin
      mq.delete();
      m_flush = 1'b0;
    end else begin
      was_nonempty = (mq.size() > 0);
      if (pop) begin
        ram_m[mq[0].idx] = mq[0].data;
        void'(mq.pop_front());
      end
      if (push) mq.push_back({idx, data});
      if (m_flush) m_flush = (mq.size() != 0);
      else if (fl && was_nonempty && (mq.size() != 0)) m_flush = 1'b1;
    end
    chk("count", 32'(dut.count_q), 32'(mq.size()));
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && (mq.size() > 0 || m_flush); k++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_dout = '0; flush = 1'b0;

    // Reset state
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("rst_idle", {31'b0, obs_idle}, 32'h1);
    chk("rst_stall", {31'b0, obs_stall}, 32'h0);
    chk("rst_din", obs_din, 32'h0);

    // Preload words 0..31 so every RAM location the bench reads is known
    for (int i = 0; i < 32; i++) cyc(1'b1, 1'b0, 1'b1, 32'(i * 4), $urandom(), 1'b0);
    drain();

    // Forwarding from the youngest queued entry
    cyc(1'b1, 1'b1, 1'b1, 32'h40, 32'h11111111, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 32'h40, 32'h22222222, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    chk("fwd_data", obs_din, 32'h22222222);
    chk("fwd_count", 32'(dut.count_q), 32'd2);
    drain();

    // Full queue stalls a write; dropping the read frees a slot
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 32'h10, 32'hA000_0004, 1'b0);
    chk("full_stall", {31'b0, obs_stall}, 32'h1);
    chk("full_count", 32'(dut.count_q), 32'd4);
    cyc(1'b1, 1'b0, 1'b1, 32'h10, 32'hA000_0004, 1'b0);
    chk("retry_stall", {31'b0, obs_stall}, 32'h0);
    chk("retry_count", 32'(dut.count_q), 32'd4);
    drain();

    // Flush three queued entries
    d0 = $urandom(); d1 = $urandom(); d2 = $urandom();
    cyc(1'b1, 1'b1, 1'b1, 32'h50, d0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 32'h54, d1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 32'h58, d2, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 32'h50, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 32'h50, 32'hDEAD_BEEF, 1'b0);
      chk("flush_stall", {31'b0, obs_stall}, 32'h1);
    end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("flush_idle", {31'b0, obs_idle}, 32'h1);
    cyc(1'b1, 1'b1, 1'b0, 32'h50, 32'h0, 1'b0);
    chk("flush_rd0", obs_din, d0);
    cyc(1'b1, 1'b1, 1'b0, 32'h54, 32'h0, 1'b0);
    chk("flush_rd1", obs_din, d1);
    cyc(1'b1, 1'b1, 1'b0, 32'h58, 32'h0, 1'b0);
    chk("flush_rd2", obs_din, d2);

    // Address wrap: 0x1000 aliases word 0
    d0 = $urandom();
    cyc(1'b1, 1'b0, 1'b1, 32'h1000, d0, 1'b0);
    drain();
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("wrap_rd", obs_din, d0);

    // Reset mid-operation discards queued writes
    p0 = ram_m[24]; p1 = ram_m[25];
    cyc(1'b1, 1'b1, 1'b1, 32'h60, ~p0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 32'h64, ~p1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("mrst_count", 32'(dut.count_q), 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 32'h60, 32'h0, 1'b0);
    chk("mrst_idle", {31'b0, obs_idle}, 32'h1);
    chk("mrst_rd0", obs_din, p0);
    cyc(1'b1, 1'b1, 1'b0, 32'h64, 32'h0, 1'b0);
    chk("mrst_rd1", obs_din, p1);

    // Simultaneous read and write returns the old value
    cyc(1'b1, 1'b0, 1'b1, 32'h20, 32'hA, 1'b0);
    drain();
    cyc(1'b1, 1'b1, 1'b1, 32'h20, 32'hB, 1'b0);
    chk("rw_old", obs_din, 32'hA);
    cyc(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    chk("rw_new", obs_din, 32'hB);
    drain();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      cyc(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          a, $urandom(), ($urandom_range(0, 15) == 0));
    end
    drain();
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("final_idle", {31'b0, obs_idle}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
